opb_rr_master_arbiter: RTL and testbench
========================================

Name: opb_rr_master_arbiter

Overview:
- Round-robin OPB master front-end that shares one OPB bus segment among NUM_REQ internal requesters (control sequencers, snapshot readers) accessing software-register slaves such as simulink2ppc status registers.
- Latches one command at a time and drives the OPB master signals.
- Handles slave xferAck, errAck, retry and the bus timeout.
- Returns read data and completion status to the winning requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 16, OPB timeout in cycles of select without ack while Sl_toutSup is low.
- MAX_RETRY, 3, retries before the arbiter gives up and flags an error.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  level request per requester.
- req_addr  in  NUM_REQ*32  address; requester i occupies bits [32i+31:32i].
- req_rnw  in  NUM_REQ  1 = read.
- req_wdata  in  NUM_REQ*32  write data.
- req_be  in  NUM_REQ*4  byte enables.
- gnt  out  NUM_REQ  one-cycle pulse: command accepted.
- done  out  NUM_REQ  one-cycle pulse: transfer finished.
- rsp_rdata  out  32  read data, valid with done.
- rsp_err  out  1  error flag, valid with done.
- rsp_tout  out  1  timeout flag, valid with done.
- OPB_select  out  1  bus select.
- OPB_ABus  out  [0:31]  address.
- OPB_BE  out  [0:3]  byte enables.
- OPB_DBus  out  [0:31]  write data; 0 on reads.
- OPB_RNW  out  1  read/not-write.
- OPB_seqAddr  out  1  tied 0.
- Sl_DBus  in  [0:31]  slave read data.
- Sl_xferAck  in  1  slave acknowledge.
- Sl_errAck  in  1  slave error.
- Sl_retry  in  1  slave retry request.
- Sl_toutSup  in  1  slave timeout suppress.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = NUM_REQ-1, retry and timeout counters 0. Reset asserted mid-transfer drops OPB_select immediately (async); no done is issued.
- States: IDLE, BUS, BACKOFF, DONE.
- IDLE: if any req, select the first set bit scanning from rr pointer+1 modulo NUM_REQ. Latch its address, rnw, wdata and be into command registers. Pulse gnt[i]. Set rr pointer = i. Go to BUS.
  - Requester may change or drop req from the cycle after gnt.
  - No req: stay in IDLE.
- BUS: OPB_select=1; OPB_ABus, OPB_BE, OPB_RNW and OPB_DBus (masked to 0 when reading) come from the command registers. Checked in priority order each cycle:
  - Sl_xferAck: capture Sl_DBus into rsp_rdata (reads only; writes leave 0), rsp_err=0. Go to DONE.
  - Sl_errAck: rsp_err=1. Go to DONE. If asserted with xferAck, errAck wins and data is still captured.
  - Sl_retry: if retry counter == MAX_RETRY, set rsp_err=1 and go to DONE. Otherwise increment the counter and go to BACKOFF.
  - Timeout counter increments while Sl_toutSup=0; it holds while toutSup=1. Reaching TIMEOUT_CYC sets rsp_err=1, rsp_tout=1 and goes to DONE.
- BACKOFF: OPB_select=0 for exactly one cycle. Timeout counter clears. Go to BUS with the same command.
- DONE: done[i] pulses; rsp_* hold until the next DONE. Select=0. Retry and timeout counters clear. Go to IDLE.
- Latency: for an idle bus with an immediate ack, gnt comes 1 cycle after req is sampled, select is high 1 cycle later, and done follows 1 cycle after xferAck.
- Select is deasserted on every state exit from BUS; there are no back-to-back selects without an IDLE cycle.
- Fairness: the just-served requester has the lowest priority on the next arbitration.

Optional Feature:
- Macro OPB_ARB_STATS_EN.
- When defined, add outputs stat_err (16), stat_tout (16) and stat_retry (16). These are saturating counters, reset to 0:
  - stat_err counts each done with rsp_err=1.
  - stat_tout counts each timeout.
  - stat_retry counts each BUS-to-BACKOFF transition.
  - Counters stick at 0xFFFF.
- When not defined, none of these ports or counters exist; behaviour is otherwise identical.

Test Plan:
- Single read: req[0] with addr 0x01004300; slave acks in the 2nd select cycle with 0xDEADBEEF. Expect gnt[0] pulse, select high 2 cycles, done[0] with rsp_rdata=0xDEADBEEF and rsp_err=0.
- Round-robin: req[0..3] all held high, every transfer acked immediately. Expect grant order 0,1,2,3,0; req[2] alone after serving 2 is still granted.
- Retry: slave asserts retry twice, then acks. Expect two 1-cycle select gaps and done with rsp_err=0. Retry on every attempt gives 4 select windows (MAX_RETRY=3), then done with rsp_err=1.
- Timeout: no ack and toutSup=0. Expect done 16 select cycles in, with rsp_err=1 and rsp_tout=1. With toutSup held for 40 cycles and then an ack, expect no timeout.
- Write plus errAck: write 0x12345678 with BE=0xF. Expect OPB_DBus=0x12345678 and RNW=0. Slave errAck gives done with rsp_err=1 and rsp_rdata=0.
- Async reset mid-BUS: OPB_Rst asserted while select=1. Expect select=0 immediately, no done, and IDLE after reset with pointer reset (req[0] served first).

Source files
------------

// File: rtl/opb_rr_master_arbiter.sv
// Round-robin OPB master front-end: shares one OPB segment among NUM_REQ requesters.
// Define OPB_ARB_STATS_EN to add saturating error/timeout/retry statistics outputs.
module opb_rr_master_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  OPB_Clk,
  input  logic                  OPB_Rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_rnw,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_be,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_tout,
  output logic                  OPB_select,
  output logic [0:31]           OPB_ABus,
  output logic [0:3]            OPB_BE,
  output logic [0:31]           OPB_DBus,
  output logic                  OPB_RNW,
  output logic                  OPB_seqAddr,
  input  logic [0:31]           Sl_DBus,
  input  logic                  Sl_xferAck,
  input  logic                  Sl_errAck,
  input  logic                  Sl_retry,
  input  logic                  Sl_toutSup
`ifdef OPB_ARB_STATS_EN
  ,
  output logic [15:0]           stat_err,
  output logic [15:0]           stat_tout,
  output logic [15:0]           stat_retry
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_BACKOFF, ST_DONE} state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] cmd_sel;
  logic [31:0]        cmd_addr;
  logic [31:0]        cmd_wdata;
  logic [3:0]         cmd_be;
  logic               cmd_rnw;
  logic [TW-1:0]      tout_cnt;
  logic [RW-1:0]      retry_cnt;

  logic               any_req;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [31:0]        win_addr;
  logic [31:0]        win_wdata;
  logic [3:0]         win_be;
  logic               win_rnw;
  int                 cand;

  // Scanning offsets downward lets the nearest requester after rr_ptr win last.
  always_comb begin
    any_req    = |req;
    win_idx    = '0;
    win_onehot = '0;
    cand       = 0;
    win_addr   = '0;
    win_wdata  = '0;
    win_be     = '0;
    win_rnw    = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[cand]) begin
        win_idx          = IW'(cand);
        win_onehot       = '0;
        win_onehot[cand] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        win_addr  = req_addr[32*i +: 32];
        win_wdata = req_wdata[32*i +: 32];
        win_be    = req_be[4*i +: 4];
        win_rnw   = req_rnw[i];
      end
    end
  end

  logic bus_live;
  logic end_xfer;
  logic end_err;
  logic end_tout;
  logic go_backoff;

  // Slave response decode; only meaningful while select is actually driven.
  always_comb begin
    bus_live   = (state == ST_BUS) && OPB_select;
    end_xfer   = 1'b0;
    end_err    = 1'b0;
    end_tout   = 1'b0;
    go_backoff = 1'b0;
    if (bus_live) begin
      if (Sl_xferAck || Sl_errAck) begin
        end_xfer = 1'b1;
        end_err  = Sl_errAck;
      end else if (Sl_retry) begin
        if (retry_cnt == RW'(MAX_RETRY)) begin
          end_xfer = 1'b1;
          end_err  = 1'b1;
        end else begin
          go_backoff = 1'b1;
        end
      end else if (!Sl_toutSup && (tout_cnt == TW'(TIMEOUT_CYC - 1))) begin
        end_xfer = 1'b1;
        end_err  = 1'b1;
        end_tout = 1'b1;
      end
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= IW'(NUM_REQ - 1);
      cmd_sel    <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_be     <= '0;
      cmd_rnw    <= 1'b0;
      tout_cnt   <= '0;
      retry_cnt  <= '0;
      gnt        <= '0;
      done       <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rsp_tout   <= 1'b0;
      OPB_select <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cmd_sel   <= win_onehot;
            cmd_addr  <= win_addr;
            cmd_wdata <= win_wdata;
            cmd_be    <= win_be;
            cmd_rnw   <= win_rnw;
            gnt       <= win_onehot;
            rr_ptr    <= win_idx;
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (!OPB_select) begin
            OPB_select <= 1'b1;
          end else if (end_xfer) begin
            OPB_select <= 1'b0;
            done       <= cmd_sel;
            rsp_rdata  <= (Sl_xferAck && cmd_rnw) ? 32'(Sl_DBus) : 32'h0;
            rsp_err    <= end_err;
            rsp_tout   <= end_tout;
            state      <= ST_DONE;
          end else if (go_backoff) begin
            OPB_select <= 1'b0;
            retry_cnt  <= retry_cnt + 1'b1;
            state      <= ST_BACKOFF;
          end else if (!Sl_toutSup) begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end
        ST_BACKOFF: begin
          // Re-enter BUS already selected so the gap is exactly this one cycle.
          tout_cnt   <= '0;
          OPB_select <= 1'b1;
          state      <= ST_BUS;
        end
        ST_DONE: begin
          tout_cnt  <= '0;
          retry_cnt <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign OPB_ABus    = OPB_select ? cmd_addr : 32'h0;
  assign OPB_BE      = OPB_select ? cmd_be : 4'h0;
  assign OPB_RNW     = OPB_select & cmd_rnw;
  assign OPB_DBus    = (OPB_select && !cmd_rnw) ? cmd_wdata : 32'h0;
  assign OPB_seqAddr = 1'b0;

`ifdef OPB_ARB_STATS_EN
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      stat_err   <= '0;
      stat_tout  <= '0;
      stat_retry <= '0;
    end else begin
      if (end_xfer && end_err && (stat_err != 16'hFFFF))
        stat_err <= stat_err + 16'd1;
      if (end_tout && (stat_tout != 16'hFFFF))
        stat_tout <= stat_tout + 16'd1;
      if (go_backoff && (stat_retry != 16'hFFFF))
        stat_retry <= stat_retry + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_opb_rr_master_arbiter.sv
// Self-checking bench for opb_rr_master_arbiter: directed plan steps plus randomized
// transactions scored against a transaction-level model of arbitration and slave outcome.
module tb_opb_rr_master_arbiter;

  localparam int NREQ = 4;
  localparam int TOUT = 16;
  localparam int MAXR = 3;
  localparam int R_ACK  = 0;
  localparam int R_ERR  = 1;
  localparam int R_BOTH = 2;
  localparam int R_NONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ-1:0]    req_rnw;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ*4-1:0]  req_be;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               rsp_tout;
  logic               OPB_select;
  logic [0:31]        OPB_ABus;
  logic [0:3]         OPB_BE;
  logic [0:31]        OPB_DBus;
  logic               OPB_RNW;
  logic               OPB_seqAddr;
  logic [0:31]        Sl_DBus;
  logic               Sl_xferAck;
  logic               Sl_errAck;
  logic               Sl_retry;
  logic               Sl_toutSup;
`ifdef OPB_ARB_STATS_EN
  logic [15:0]        stat_err;
  logic [15:0]        stat_tout;
  logic [15:0]        stat_retry;
`endif

  logic [31:0] r_addr [NREQ];
  logic [31:0] r_wdata[NREQ];
  logic [3:0]  r_be   [NREQ];
  logic        r_rnw  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_addr[32*g +: 32]  = r_addr[g];
    assign req_wdata[32*g +: 32] = r_wdata[g];
    assign req_be[4*g +: 4]      = r_be[g];
    assign req_rnw[g]            = r_rnw[g];
  end

  opb_rr_master_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TOUT), .MAX_RETRY(MAXR)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst),
    .req(req), .req_addr(req_addr), .req_rnw(req_rnw), .req_wdata(req_wdata), .req_be(req_be),
    .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tout(rsp_tout),
    .OPB_select(OPB_select), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE), .OPB_DBus(OPB_DBus),
    .OPB_RNW(OPB_RNW), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck),
    .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup)
`ifdef OPB_ARB_STATS_EN
    , .stat_err(stat_err), .stat_tout(stat_tout), .stat_retry(stat_retry)
`endif
  );

  int tests = 0;
  int fails = 0;
  int ptr;
  int m_err, m_tout, m_retry;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i]  = $urandom;
      r_wdata[i] = $urandom;
      r_be[i]    = 4'($urandom_range(1, 15));
      r_rnw[i]   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic slave_idle();
    Sl_xferAck = 1'b0;
    Sl_errAck  = 1'b0;
    Sl_retry   = 1'b0;
    Sl_toutSup = 1'b0;
    Sl_DBus    = 32'h0;
  endtask

  // One transaction: mask of requesters, slave script (retries, final response,
  // select cycles before the final response, toutSup level, read data).
  task automatic run_txn(input logic [NREQ-1:0] mask, input int n_retry, input int resp,
                         input int dly, input logic sup_in, input logic [31:0] sdata);
    int win, j, exp_windows, fin_len, exp_sel;
    int windows, sel_cycles, wcyc, gap;
    logic in_win, got_done, sup, e_err, e_tout;
    logic [31:0] e_rd, w_addr, w_wdata;
    logic [3:0] w_be;
    logic w_rnw;

    sup = (resp == R_NONE) ? 1'b0 : sup_in;
    win = -1;
    for (int k = NREQ; k >= 1; k--) begin
      j = (ptr + k) % NREQ;
      if (mask[j]) win = j;
    end
    w_addr = r_addr[win]; w_wdata = r_wdata[win]; w_be = r_be[win]; w_rnw = r_rnw[win];

    if (n_retry > MAXR) begin
      exp_windows = MAXR + 1; fin_len = 1;
      e_err = 1'b1; e_tout = 1'b0; e_rd = 32'h0;
    end else begin
      exp_windows = n_retry + 1;
      if (resp == R_NONE || (!sup && dly >= TOUT)) begin
        fin_len = TOUT; e_err = 1'b1; e_tout = 1'b1; e_rd = 32'h0;
      end else begin
        fin_len = dly + 1;
        e_err   = (resp != R_ACK);
        e_tout  = 1'b0;
        e_rd    = (resp != R_ERR && w_rnw) ? sdata : 32'h0;
      end
    end
    exp_sel = (exp_windows - 1) + fin_len;

    req = mask;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(1 << win));
    ptr = win;
    req = '0;
    rand_reqs();  // command must already be latched

    windows = 0; sel_cycles = 0; wcyc = 0; gap = 0; in_win = 1'b0; got_done = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge clk);
      if (c == 0) chk("sel_latency", 32'(OPB_select), 32'd1);
      if (done !== '0) begin
        got_done = 1'b1;
      end else if (OPB_select) begin
        if (!in_win) begin
          if (windows > 0) chk("backoff_gap", 32'(gap), 32'd1);
          windows++; in_win = 1'b1; wcyc = 0;
          chk("abus", 32'(OPB_ABus), w_addr);
          chk("be", 32'(OPB_BE), 32'(w_be));
          chk("rnw", 32'(OPB_RNW), 32'(w_rnw));
          chk("dbus", 32'(OPB_DBus), w_rnw ? 32'h0 : w_wdata);
          chk("seqaddr", 32'(OPB_seqAddr), 32'd0);
        end
        wcyc++; sel_cycles++;
        slave_idle();
        Sl_DBus = $urandom;
        if (windows <= n_retry) begin
          Sl_retry = 1'b1;
        end else begin
          Sl_toutSup = sup;
          if (resp != R_NONE && wcyc == dly + 1) begin
            Sl_xferAck = (resp != R_ERR);
            Sl_errAck  = (resp != R_ACK);
            Sl_DBus    = sdata;
          end
        end
      end else begin
        if (in_win) gap = 0;
        in_win = 1'b0;
        gap++;
        slave_idle();
      end
    end
    slave_idle();

    if (!got_done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done", 32'(done), 32'(1 << win));
      chk("done_latency", 32'(in_win), 32'd1);
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("rsp_tout", 32'(rsp_tout), 32'(e_tout));
      chk("windows", 32'(windows), 32'(exp_windows));
      chk("sel_cycles", 32'(sel_cycles), 32'(exp_sel));
      chk("sel_at_done", 32'(OPB_select), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      if (e_err && m_err < 16'hFFFF) m_err++;
      if (e_tout && m_tout < 16'hFFFF) m_tout++;
      m_retry += (n_retry > MAXR) ? MAXR : n_retry;
    end
  endtask

  initial begin
    int mask, nr, rs;
    req = '0;
    slave_idle();
    rand_reqs();
    ptr = NREQ - 1;
    m_err = 0; m_tout = 0; m_retry = 0;
    repeat (3) @(negedge clk);
    chk("rst_select", 32'(OPB_select), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'({rsp_err, rsp_tout}), 32'd0);
    chk("rst_abus", 32'(OPB_ABus), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    rand_reqs(); r_addr[0] = 32'h01004300; r_rnw[0] = 1'b1;
    run_txn(4'b0001, 0, R_ACK, 1, 1'b0, 32'hDEADBEEF);

    rand_reqs(); run_txn(4'b0010, 2, R_ACK, 0, 1'b0, $urandom);
    rand_reqs(); run_txn(4'b1000, 9, R_ACK, 0, 1'b0, $urandom);

    rand_reqs(); run_txn(4'b0100, 0, R_NONE, 0, 1'b0, 32'h0);
    rand_reqs(); r_rnw[1] = 1'b1; run_txn(4'b0010, 0, R_ACK, 40, 1'b1, 32'hA5A50F0F);

    rand_reqs(); r_rnw[3] = 1'b0; r_wdata[3] = 32'h12345678; r_be[3] = 4'hF;
    run_txn(4'b1000, 0, R_ERR, 0, 1'b0, 32'hFFFFFFFF);

    // Reset while the bus is selected
    rand_reqs(); req = 4'b0100;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("pre_rst_select", 32'(OPB_select), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_select", 32'(OPB_select), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("rst_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    ptr = NREQ - 1;
    m_err = 0; m_tout = 0; m_retry = 0;
    @(negedge clk);

    for (int n = 0; n < 5; n++) begin
      rand_reqs(); run_txn(4'b1111, 0, R_ACK, 0, 1'b0, $urandom);
    end
    rand_reqs(); run_txn(4'b0100, 0, R_ACK, 0, 1'b0, $urandom);
    rand_reqs(); run_txn(4'b0100, 0, R_ACK, 0, 1'b0, $urandom);

    for (int n = 0; n < 40; n++) begin
      rand_reqs();
      mask = $urandom_range(1, (1 << NREQ) - 1);
      nr   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
      rs   = $urandom_range(0, 3);
      run_txn(NREQ'(mask), nr, rs, $urandom_range(0, 20), 1'($urandom_range(0, 1)), $urandom);
    end

`ifdef OPB_ARB_STATS_EN
    chk("stat_err", 32'(stat_err), 32'(m_err));
    chk("stat_tout", 32'(stat_tout), 32'(m_tout));
    chk("stat_retry", 32'(stat_retry), 32'(m_retry));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
